muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO state, parametrised in operand width.
- Replaces the single-cycle combinational HI/LO arithmetic in the execute stage (MULT, MULTU, MADD, MSUB, MTHI, MTLO) with a sequential radix-2 engine that also adds DIV/DIVU.
- Sits beside the ALU in EX. The hazard unit stalls on Busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request, sampled on rising edge.
- Op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO.
- A  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- B  in  WIDTH  multiplier / divisor.
- Busy  out  1  high while an iterative op is in flight.
- Done  out  1  one-cycle pulse; Hi/Lo are final in that cycle.
- DivByZero  out  1  pulses with Done when DIV/DIVU has B==0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state=IDLE. Rst has priority over everything.
- States: IDLE, RUN, FIX.
- IDLE and Start accepted:
  - MTHI/MTLO: Hi (resp. Lo) <= A at that edge. Next cycle Done=1. Busy never rises.
  - DIV/DIVU with B==0: Hi/Lo unchanged. Next cycle Done=1 and DivByZero=1.
  - Otherwise: latch operand magnitudes (signed ops use |A|, |B|), result sign and op. Go to RUN with count=WIDTH.
- RUN: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle. count decrements; at count==1 go to FIX.
- FIX:
  - Apply sign correction and write Hi/Lo. Return to IDLE.
  - Done=1 in the following cycle.
  - Busy=1 in every RUN and FIX cycle, 0 otherwise.
- Latency:
  - Start sampled at edge 0 gives Done in cycle WIDTH+2 (34 for WIDTH=32), with Busy high in cycles 1..WIDTH+1.
  - Single-cycle ops give Done in cycle 1.
- Multiply: full 2*WIDTH product {Hi,Lo}.
  - MULT signed, MULTU unsigned.
  - MADD: {Hi,Lo} <= {Hi,Lo} + signed product. MSUB: {Hi,Lo} <= {Hi,Lo} − signed product. Both wrap modulo 2^(2*WIDTH), using the {Hi,Lo} value at FIX time.
- Divide: Lo = quotient, Hi = remainder.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
  - Most-negative ÷ −1 gives Lo = most-negative, Hi = 0. No exception.
- Start while Busy=1 is ignored; no queueing.
- Start in the Done cycle is accepted (back-to-back issue).
- Op/A/B only need to be valid in the Start cycle.
- Rst mid-operation abandons the op: Hi=Lo=0 at the next edge, no Done pulse.
- Done and DivByZero are registered outputs. Hi/Lo are direct register outputs and hold between ops.

Decomposition:
- Shared package muldiv_pkg:
  - Op encodings (OP_MULT…OP_MTLO).
  - State encoding (S_IDLE, S_RUN, S_FIX).
  - Count width localparam $clog2(WIDTH+1).
- One sub-module, muldiv_step: combinational single iteration, parametrised by WIDTH.
  - Inputs: partial accumulator, shift register, operand, mode.
  - Outputs: next accumulator and next shift register.
  - Lets the control FSM stay in muldiv_unit.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=7 → Done in cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high cycles 1..33.
- MULTU A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- MTHI A=5, then MTLO A=10, then MADD A=3 B=4 → Hi=5, Lo=22. Then MSUB A=2 B=11 → Hi=5, Lo=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=7, B=0 → Done and DivByZero both pulse in cycle 1; Hi/Lo unchanged.
- MULT in flight, Start with MTLO at cycle 5 → ignored, Lo not written. Separately, Rst at cycle 10 of a DIV → Busy=0, Hi=Lo=0, no Done pulse. Start issued in a Done cycle → accepted, Busy high next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] operand,
    input  logic             mode,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] sr_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign sum     = {1'b0, acc} + {1'b0, operand & {WIDTH{sr[0]}}};
    assign shifted = {acc, sr[WIDTH-1]};
    assign ge      = shifted >= {1'b0, operand};
    // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
    assign diff    = shifted[WIDTH-1:0] - operand;

    always_comb begin
        acc_next = sum[WIDTH:1];
        sr_next  = {sum[0], sr[WIDTH-1:1]};
        if (mode == MODE_DIV) begin
            acc_next = ge ? diff : shifted[WIDTH-1:0];
            sr_next  = {sr[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential multiply/divide unit with HI/LO state; MTHI/MTLO and divide-by-zero finish in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [WIDTH-1:0] opnd, opnd_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d, dbz_d;

    logic [WIDTH-1:0]   acc_step, sr_step;
    logic               is_div_q;
    logic               signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_mag, prod_s, hilo_acc;
    logic [WIDTH-1:0]   quot, rem;

    // Operand magnitudes and signs captured at issue
    assign signed_op = !(op == OP_MULTU || op == OP_DIVU);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .sr       (sr),
        .operand  (opnd),
        .mode     (is_div_q ? MODE_DIV : MODE_MUL),
        .acc_next (acc_step),
        .sr_next  (sr_step)
    );

    // Sign correction and HI/LO accumulation applied in FIX
    assign prod_mag = {acc, sr};
    assign prod_s   = neg_q ? -prod_mag : prod_mag;
    assign hilo_acc = (op_q == OP_MSUB) ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
    assign quot     = neg_q ? -sr : sr;
    assign rem      = rem_neg_q ? -acc : acc;

    always_comb begin
        state_d   = state;
        count_d   = count;
        acc_d     = acc;
        sr_d      = sr;
        opnd_d    = opnd;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi;
        lo_d      = lo;
        busy_d    = busy;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == OP_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end else if ((op == OP_DIV || op == OP_DIVU) && b == '0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        acc_d     = '0;
                        sr_d      = a_mag;
                        opnd_d    = b_mag;
                        op_d      = op;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        count_d   = CNT_W'(WIDTH);
                        busy_d    = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d   = acc_step;
                sr_d    = sr_step;
                count_d = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else if (op_q == OP_MADD || op_q == OP_MSUB) begin
                    {hi_d, lo_d} = hilo_acc;
                end else begin
                    {hi_d, lo_d} = prod_s;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            acc         <= '0;
            sr          <= '0;
            opnd        <= '0;
            op_q        <= OP_MULT;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            acc         <= acc_d;
            sr          <= sr_d;
            opnd        <= opnd_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            hi          <= hi_d;
            lo          <= lo_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32); cycle k is the cycle after edge k of a Start.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int nvec;
    int nerr;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive Start for one edge, then scramble operands; returns at the cycle-1 sample point.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'd7; a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5;
    endtask

    // Sample each negedge until Done (bounded); dcyc = -1 if Done never came.
    task automatic wait_done(input int first_cyc, output int dcyc, output int bfirst,
                             output int blast, output logic dbz);
        dcyc = -1; bfirst = -1; blast = -1; dbz = 1'b0;
        for (int c = first_cyc; c < 80 && dcyc < 0; c++) begin
            if (busy) begin
                if (bfirst < 0) bfirst = c;
                blast = c;
            end
            if (done) begin
                dcyc = c;
                dbz  = div_by_zero;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst = 1'b0;
    endtask

    task automatic test_mult();
        int dc, bf, bl; logic z;
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (dc !== 34) begin nerr++; $display("FAIL mult_done_cycle: got %0d want 34", dc); end
        nvec++; if (bf !== 1) begin nerr++; $display("FAIL mult_busy_first: got %0d want 1", bf); end
        nvec++; if (bl !== 33) begin nerr++; $display("FAIL mult_busy_last: got %0d want 33", bl); end
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
        nvec++; if (lo !== 32'hFFFF_FFEB) begin nerr++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFF_FFEB); end
        nvec++; if (z !== 1'b0) begin nerr++; $display("FAIL mult_dbz: got %b want 0", z); end
    endtask

    task automatic test_multu();
        int dc, bf, bl; logic z;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (dc !== 34) begin nerr++; $display("FAIL multu_done_cycle: got %0d want 34", dc); end
        nvec++; if (hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
        nvec++; if (lo !== 32'h0000_0001) begin nerr++; $display("FAIL multu_lo: got %h want %h", lo, 32'h1); end
    endtask

    task automatic test_madd_msub();
        int dc, bf, bl; logic z;
        issue(3'd6, 32'd5, 32'd0);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (dc !== 1) begin nerr++; $display("FAIL mthi_done_cycle: got %0d want 1", dc); end
        nvec++; if (bf !== -1) begin nerr++; $display("FAIL mthi_busy: got %0d want -1", bf); end
        nvec++; if (hi !== 32'd5) begin nerr++; $display("FAIL mthi_hi: got %h want %h", hi, 32'd5); end
        issue(3'd7, 32'd10, 32'd0);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (lo !== 32'd10) begin nerr++; $display("FAIL mtlo_lo: got %h want %h", lo, 32'd10); end
        issue(3'd2, 32'd3, 32'd4);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (hi !== 32'd5) begin nerr++; $display("FAIL madd_hi: got %h want %h", hi, 32'd5); end
        nvec++; if (lo !== 32'd22) begin nerr++; $display("FAIL madd_lo: got %h want %h", lo, 32'd22); end
        issue(3'd3, 32'd2, 32'd11);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (hi !== 32'd5) begin nerr++; $display("FAIL msub_hi: got %h want %h", hi, 32'd5); end
        nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL msub_lo: got %h want %h", lo, 32'd0); end
        // signed product -1 borrows across the HI/LO boundary
        issue(3'd2, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (hi !== 32'd4) begin nerr++; $display("FAIL madd_neg_hi: got %h want %h", hi, 32'd4); end
        nvec++; if (lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL madd_neg_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
    endtask

    task automatic test_div();
        int dc, bf, bl; logic z;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (dc !== 34) begin nerr++; $display("FAIL div_done_cycle: got %0d want 34", dc); end
        nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_neg_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
        nvec++; if (hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_neg_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (lo !== 32'h8000_0000) begin nerr++; $display("FAIL div_ovf_lo: got %h want %h", lo, 32'h8000_0000); end
        nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL div_ovf_hi: got %h want %h", hi, 32'h0); end
        nvec++; if (z !== 1'b0) begin nerr++; $display("FAIL div_ovf_dbz: got %b want 0", z); end
        issue(3'd5, 32'd100, 32'd7);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (lo !== 32'd14) begin nerr++; $display("FAIL divu_lo: got %h want %h", lo, 32'd14); end
        nvec++; if (hi !== 32'd2) begin nerr++; $display("FAIL divu_hi: got %h want %h", hi, 32'd2); end
        issue(3'd4, 32'd7, 32'hFFFF_FFFE);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_negb_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
        nvec++; if (hi !== 32'd1) begin nerr++; $display("FAIL div_negb_hi: got %h want %h", hi, 32'd1); end
    endtask

    task automatic test_div_zero();
        int dc, bf, bl; logic z;
        issue(3'd5, 32'd7, 32'd0);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (dc !== 1) begin nerr++; $display("FAIL dbz_done_cycle: got %0d want 1", dc); end
        nvec++; if (z !== 1'b1) begin nerr++; $display("FAIL dbz_flag: got %b want 1", z); end
        nvec++; if (bf !== -1) begin nerr++; $display("FAIL dbz_busy: got %0d want -1", bf); end
        nvec++; if (hi !== 32'd1) begin nerr++; $display("FAIL dbz_hi: got %h want %h", hi, 32'd1); end
        nvec++; if (lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL dbz_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
        @(negedge clk);
        nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL dbz_pulse_width: got %b want 0", div_by_zero); end
    endtask

    task automatic test_busy_ignore();
        int dc, bf, bl; logic z;
        issue(3'd0, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        op = 3'd7; a = 32'h0000_1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, dc, bf, bl, z);
        nvec++; if (dc !== 34) begin nerr++; $display("FAIL ignore_done_cycle: got %0d want 34", dc); end
        nvec++; if (lo !== 32'd42) begin nerr++; $display("FAIL ignore_lo: got %h want %h", lo, 32'd42); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL ignore_hi: got %h want %h", hi, 32'd0); end
        repeat (3) @(negedge clk);
        nvec++; if (lo !== 32'd42) begin nerr++; $display("FAIL ignore_lo_later: got %h want %h", lo, 32'd42); end
    endtask

    task automatic test_reset_mid();
        int dc, bf, bl; logic z;
        issue(3'd4, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL rstmid_hi: got %h want %h", hi, 32'd0); end
        nvec++; if (lo !== 32'd0) begin nerr++; $display("FAIL rstmid_lo: got %h want %h", lo, 32'd0); end
        wait_done(11, dc, bf, bl, z);
        nvec++; if (dc !== -1) begin nerr++; $display("FAIL rstmid_no_done: got %0d want -1", dc); end
    endtask

    task automatic test_back_to_back();
        int dc, bf, bl; logic z;
        issue(3'd1, 32'd2, 32'd3);
        wait_done(1, dc, bf, bl, z);
        nvec++; if (lo !== 32'd6) begin nerr++; $display("FAIL b2b_first_lo: got %h want %h", lo, 32'd6); end
        // Start asserted during the Done cycle
        op = 3'd1; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_done(1, dc, bf, bl, z);
        nvec++; if (dc !== 34) begin nerr++; $display("FAIL b2b_done_cycle: got %0d want 34", dc); end
        nvec++; if (lo !== 32'd25) begin nerr++; $display("FAIL b2b_lo: got %h want %h", lo, 32'd25); end
        nvec++; if (hi !== 32'd0) begin nerr++; $display("FAIL b2b_hi: got %h want %h", hi, 32'd0); end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        test_reset();
        test_mult();
        test_multu();
        test_madd_msub();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
